// File: rtl/adc_capture_trigger.sv
// Pre/post-trigger capture ring for the AD9220 sample stream: detects new samples,
// triggers on a level crossing or force, then streams a DEPTH-sample record oldest first.
module adc_capture_trigger #(
  parameter int DEPTH = 1024,
  parameter int PRE   = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        adc_clk_driver,
  input  logic [12:0] adc_data,
  input  logic        arm,
  input  logic        force_trig,
  input  logic [11:0] trig_level,
  input  logic        trig_falling,
  output logic        busy,
  output logic        triggered,
  output logic        otr_seen,
  output logic [12:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PRE_A     = AW'(PRE);
  localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRE - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LAST_C    = (AW+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_READ = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          drv_q;
  logic [AW-1:0] wp_q, wp_d, pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d, rd_ptr_q, rd_ptr_d;
  logic [11:0]   prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic [AW:0]   iss_cnt_q, iss_cnt_d;
  logic          infl_q, infl_d, infl_last_q, infl_last_d;
  logic [12:0]   skid_data_q, skid_data_d, out_data_q, out_data_d;
  logic          skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic          busy_q, busy_d, triggered_q, triggered_d, otr_q, otr_d;
  logic [12:0]   rdata_q;
  logic [12:0]   ram_q [DEPTH];

  logic          new_s, we_s, rise_s, fall_s, trig_s, pop_s, out_free_s, issue_s;
  logic [11:0]   cur_s;
  logic [1:0]    buf_cnt_s;

  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign otr_seen  = otr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  // Sample RAM: written in the detect cycle, read back with one clock of latency.
  always_ff @(posedge clk) begin
    if (we_s) begin
      ram_q[wp_q] <= adc_data;
    end
    rdata_q <= ram_q[rd_ptr_q];
  end

  // Next-state logic: sample detect, trigger decision, ring pointers and read skid pipeline.
  always_comb begin
    new_s  = adc_clk_driver & ~drv_q;
    cur_s  = adc_data[11:0];
    rise_s = (prev_q < trig_level) && (cur_s >= trig_level);
    fall_s = (prev_q > trig_level) && (cur_s <= trig_level);
    trig_s = force_trig || (prev_valid_q && (trig_falling ? fall_s : rise_s));
    we_s   = new_s && ((state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST));

    state_d      = state_q;
    wp_d         = wp_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    iss_cnt_d    = iss_cnt_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    busy_d       = busy_q;
    triggered_d  = triggered_q;
    otr_d        = otr_q;

    // Output slot, skid slot and in-flight read together never hold more than two words.
    pop_s      = out_valid_q & out_ready;
    out_free_s = ~out_valid_q | out_ready;
    buf_cnt_s  = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(infl_q) - 2'(pop_s);
    issue_s    = (state_q == S_READ) && (iss_cnt_q != DEPTH_C) && (buf_cnt_s <= 2'd1);
    infl_d      = issue_s;
    infl_last_d = issue_s && (iss_cnt_q == LAST_C);
    if (issue_s) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      iss_cnt_d = iss_cnt_q + 1'b1;
    end else begin
      rd_ptr_d  = rd_ptr_q;
    end

    if (out_free_s) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_valid_d  = 1'b1;
        skid_valid_d = infl_q;
        skid_data_d  = rdata_q;
        skid_last_d  = infl_last_q;
      end else if (infl_q) begin
        out_data_d   = rdata_q;
        out_last_d   = infl_last_q;
        out_valid_d  = 1'b1;
      end else begin
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
      end
    end else if (infl_q && !skid_valid_q) begin
      skid_data_d  = rdata_q;
      skid_last_d  = infl_last_q;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid_q;
    end

    if (we_s) begin
      wp_d         = wp_q + 1'b1;
      prev_d       = cur_s;
      prev_valid_d = 1'b1;
      otr_d        = otr_q | adc_data[12];
    end else begin
      wp_d         = wp_q;
    end

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          wp_d         = '0;
          pre_cnt_d    = '0;
          otr_d        = 1'b0;
          prev_valid_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_PRE;
        end else begin
          state_d      = S_IDLE;
        end
      end
      S_PRE: begin
        if (new_s) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          state_d   = (pre_cnt_d == PRE_A) ? S_WAIT : S_PRE;
        end else begin
          state_d   = S_PRE;
        end
      end
      S_WAIT: begin
        if (new_s && trig_s) begin
          triggered_d = 1'b1;
          rd_ptr_d    = wp_q - PRE_A;
          post_cnt_d  = POST_INIT;
          iss_cnt_d   = '0;
          state_d     = (POST_INIT == '0) ? S_READ : S_POST;
        end else begin
          state_d     = S_WAIT;
        end
      end
      S_POST: begin
        if (new_s) begin
          post_cnt_d = post_cnt_q - 1'b1;
          iss_cnt_d  = '0;
          state_d    = (post_cnt_q == AW'(1)) ? S_READ : S_POST;
        end else begin
          state_d    = S_POST;
        end
      end
      S_READ: begin
        if (pop_s && out_last_q) begin
          triggered_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d     = S_READ;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      drv_q        <= 1'b0;
      wp_q         <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      rd_ptr_q     <= '0;
      prev_q       <= 12'd0;
      prev_valid_q <= 1'b0;
      iss_cnt_q    <= '0;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
      skid_data_q  <= 13'd0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
      out_data_q   <= 13'd0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      otr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      drv_q        <= adc_clk_driver;
      wp_q         <= wp_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      iss_cnt_q    <= iss_cnt_d;
      infl_q       <= infl_d;
      infl_last_q  <= infl_last_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      triggered_q  <= triggered_d;
      otr_q        <= otr_d;
    end
  end

endmodule

// File: tb/tb_adc_capture_trigger.sv
// Directed bench for adc_capture_trigger (DEPTH=16, PRE=4): table of capture steps plus
// hand-written mid-capture reset and arm-during-read sequence.
module tb_adc_capture_trigger;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int K_CFG = 0, K_ARM = 1, K_SMP = 2, K_RD = 3, K_OTR = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        drv = 1'b0;
  logic [12:0] adc_data = 13'd0;
  logic        arm = 1'b0;
  logic        force_trig = 1'b0;
  logic [11:0] trig_level = 12'd100;
  logic        trig_falling = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, triggered, otr_seen, out_valid, out_last;
  logic [12:0] out_data;

  adc_capture_trigger #(.DEPTH(DEPTH), .PRE(PRE)) dut (
    .clk(clk), .rstn(rstn), .adc_clk_driver(drv), .adc_data(adc_data),
    .arm(arm), .force_trig(force_trig), .trig_level(trig_level),
    .trig_falling(trig_falling), .busy(busy), .triggered(triggered),
    .otr_seen(otr_seen), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [12:0] data;
    logic        frc;
    logic        exp_trig;
    int          tidx;
    int          pct;
    logic        arm_rd;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] stored[$];
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic void add(input int k, input logic [12:0] d, input logic f,
                              input logic e, input int t, input int p, input logic a);
    vec_t v;
    v.kind = k; v.data = d; v.frc = f; v.exp_trig = e;
    v.tidx = t; v.pct = p; v.arm_rd = a;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic send(input logic [12:0] d, input logic f);
    @(negedge clk); adc_data = d; force_trig = f; drv = 1'b1;
    @(negedge clk); @(negedge clk); drv = 1'b0;
    @(negedge clk); @(negedge clk); force_trig = 1'b0;
    stored.push_back(d);
  endtask

  task automatic do_arm();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    stored.delete();
    chk("busy_after_arm", busy, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_triggered"}, triggered, 0);
    chk({tag, "_otr_seen"}, otr_seen, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  // Reads one record; expected words come from the bench's own list of stored samples.
  task automatic read_record(input int tidx, input int pct, input logic arm_rd);
    int got, cyc, first_cyc;
    logic stall, pl, v, l, r;
    logic [12:0] pd, d;
    got = 0; cyc = 0; first_cyc = 0; stall = 1'b0; pd = 13'd0; pl = 1'b0;
    while (got < DEPTH && cyc < 2000) begin
      @(negedge clk);
      v = out_valid; d = out_data; l = out_last;
      if (stall) begin
        chk("stall_valid", v, 1);
        chk("stall_data", d, pd);
        chk("stall_last", l, pl);
      end
      r = ($urandom_range(0, 99) < pct);
      out_ready = r;
      arm = arm_rd && (cyc % 3 == 1);
      if (v && r) begin
        if (got == 0) first_cyc = cyc;
        chk($sformatf("rec_data[%0d]", got), d, stored[tidx - PRE + got]);
        chk($sformatf("rec_last[%0d]", got), l, (got == DEPTH - 1));
        got++;
        if (got == DEPTH && pct == 100) chk("no_bubble", cyc - first_cyc, DEPTH - 1);
      end
      stall = v && !r; pd = d; pl = l;
      cyc++;
    end
    arm = 1'b0;
    chk("rd_transfers", got, DEPTH);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_rd_valid", out_valid, 0);
    chk("post_rd_busy", busy, 0);
    chk("post_rd_triggered", triggered, 0);
  endtask

  initial begin
    logic [12:0] d;
    // Basic rising capture, force coinciding with the crossing.
    add(K_CFG, 13'd100, 1'b0, 1'b0, 0, 0, 1'b0);
    add(K_ARM, 13'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 18; i++) add(K_SMP, 13'(70 + 5 * i), (i == 6), (i >= 6), 0, 0, 1'b0);
    add(K_RD, 13'd0, 1'b0, 1'b0, 6, 100, 1'b0);
    // Crossing inside PRE_FILL is masked; next crossing 50->120 is taken.
    add(K_ARM, 13'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    add(K_SMP, 13'd90, 1'b0, 1'b0, 0, 0, 1'b0);
    add(K_SMP, 13'd95, 1'b0, 1'b0, 0, 0, 1'b0);
    add(K_SMP, 13'd100, 1'b0, 1'b0, 0, 0, 1'b0);
    add(K_SMP, 13'd105, 1'b0, 1'b0, 0, 0, 1'b0);
    add(K_SMP, 13'd110, 1'b0, 1'b0, 0, 0, 1'b0);
    add(K_SMP, 13'd115, 1'b0, 1'b0, 0, 0, 1'b0);
    add(K_SMP, 13'd50, 1'b0, 1'b0, 0, 0, 1'b0);
    add(K_SMP, 13'd120, 1'b0, 1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 11; i++) add(K_SMP, 13'(125 + 5 * i), 1'b0, 1'b1, 0, 0, 1'b0);
    add(K_RD, 13'd0, 1'b0, 1'b0, 7, 100, 1'b0);
    // Falling mode, constant 3000: no crossing; force in PRE_FILL ignored, force in WAIT fires.
    add(K_CFG, 13'd2000, 1'b1, 1'b0, 0, 0, 1'b0);
    add(K_ARM, 13'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 22; i++) add(K_SMP, 13'd3000, (i == 1 || i == 10), (i >= 10), 0, 0, 1'b0);
    add(K_RD, 13'd0, 1'b0, 1'b0, 10, 100, 1'b0);
    // Trigger on the first WAIT sample, read under 30% backpressure.
    add(K_CFG, 13'd100, 1'b0, 1'b0, 0, 0, 1'b0);
    add(K_ARM, 13'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 16; i++) add(K_SMP, 13'(60 + 10 * i), 1'b0, (i >= 4), 0, 0, 1'b0);
    add(K_RD, 13'd0, 1'b0, 1'b0, 4, 30, 1'b0);
    // Long WAIT with OTR samples, record crosses the ring wrap.
    add(K_ARM, 13'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) add(K_SMP, 13'(10 + i), 1'b0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      d = 13'(20 + i);
      if (i == 5 || i == 38) d[12] = 1'b1;
      add(K_SMP, d, 1'b0, 1'b0, 0, 0, 1'b0);
    end
    add(K_SMP, 13'd200, 1'b0, 1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 11; i++) add(K_SMP, 13'(201 + i), 1'b0, 1'b1, 0, 0, 1'b0);
    add(K_RD, 13'd0, 1'b0, 1'b0, 44, 100, 1'b0);
    add(K_OTR, 13'd0, 1'b1, 1'b0, 0, 0, 1'b0);
    add(K_ARM, 13'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    add(K_OTR, 13'd0, 1'b0, 1'b0, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].kind)
        K_CFG: begin trig_level = vecs[i].data[11:0]; trig_falling = vecs[i].frc; end
        K_ARM: do_arm();
        K_SMP: begin
          send(vecs[i].data, vecs[i].frc);
          chk($sformatf("trig[%0d]", i), triggered, vecs[i].exp_trig);
          chk($sformatf("busy[%0d]", i), busy, 1);
        end
        K_RD:  read_record(vecs[i].tidx, vecs[i].pct, vecs[i].arm_rd);
        K_OTR: chk($sformatf("otr_seen[%0d]", i), otr_seen, vecs[i].frc);
        default: chk("bad_vector_kind", vecs[i].kind, 0);
      endcase
    end

    // Mid-capture reset during POST_FILL (capture already armed by the table).
    for (int i = 0; i < 4; i++) send(13'(30 + 10 * i), 1'b0);
    send(13'd150, 1'b0);
    for (int i = 0; i < 3; i++) send(13'(160 + i), 1'b0);
    chk("pre_reset_triggered", triggered, 1);
    @(negedge clk); rstn = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_reset_idle", busy, 0);

    // Fresh capture, arm pulsed repeatedly during READ.
    do_arm();
    for (int i = 0; i < 4; i++) send(13'(40 + i), 1'b0);
    send(13'd300, 1'b0);
    for (int i = 0; i < 11; i++) send(13'(310 + i), 1'b0);
    chk("read_state_busy", busy, 1);
    read_record(4, 100, 1'b1);
    repeat (3) @(negedge clk);
    chk("idle_after_arm_in_read", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
